seq_divider: RTL and testbench

Multi-cycle sequential divider using the non-restoring algorithm: one quotient bit per clock, with a start/done handshake. It is the inverse companion to the team's sequential Booth multiplier, so the arithmetic unit can do both multiply and divide. The controller FSM and the A/Q/M datapath live in one module. Operands are captured on start, and results hold stable until the next accepted start.

---
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: non-restoring sequential divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's complement operands (default: unsigned).
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX
  } state_t;

  state_t state;
  state_t state_d;

  logic [WIDTH:0]   a_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] m_r;
  logic [CW-1:0]    count;

  logic             accept;
  logic             zero_div;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   a_step;
  logic [WIDTH:0]   a_fix;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;

  assign accept   = (state == IDLE) && start;
  assign zero_div = (divisor == '0);
  assign busy     = (state != IDLE);

  assign a_sh   = {a_r[WIDTH-1:0], q_r[WIDTH-1]};
  assign a_step = a_r[WIDTH] ? a_sh + {1'b0, m_r}
                             : a_sh - {1'b0, m_r};
  assign a_fix  = a_r[WIDTH] ? a_r + {1'b0, m_r} : a_r;

`ifdef DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;

  assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dvs_mag = divisor[WIDTH-1] ? -divisor : divisor;
  assign q_res   = neg_q ? -q_r : q_r;
  assign r_res   = neg_r ? -a_fix[WIDTH-1:0]
                         : a_fix[WIDTH-1:0];
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign q_res   = q_r;
  assign r_res   = a_fix[WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state: zero divisor completes in IDLE without iterating
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (accept && !zero_div) state_d = ITER;
      ITER: if (count == CW'(1))     state_d = FIX;
      FIX:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, iterate, correct and publish results
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r         <= '0;
      q_r         <= '0;
      m_r         <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (zero_div) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              a_r         <= '0;
              q_r         <= dvd_mag;
              m_r         <= dvs_mag;
              count       <= CW'(WIDTH);
              div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
              neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              neg_r <= dividend[WIDTH-1];
`endif
            end
          end
        end
        ITER: begin
          a_r   <= a_step;
          q_r   <= {q_r[WIDTH-2:0], ~a_step[WIDTH]};
          count <= count - CW'(1);
        end
        FIX: begin
          a_r       <= a_fix;
          quotient  <= q_res;
          remainder <= r_res;
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed checks of latency, results, handshake and reset.
// Signed vectors are exercised when DIV_SIGNED_EN is defined.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int n_checks;
  int n_fail;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: start for one cycle, optional ignored start at
  // cycle 5, count busy cycles and done pulses through edge W+2.
  task automatic run_op(input string tag,
                        input logic [W-1:0] dvd,
                        input logic [W-1:0] dvs,
                        input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r,
                        input bit glitch);
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [W-1:0] q_at;
    logic [W-1:0] r_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    q_at     = '0;
    r_at     = '0;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " dbz_clr"}, 32'(div_by_zero), 32'd0);
    if (busy) busy_cnt++;
    for (int i = 1; i <= W + 2; i++) begin
      if (glitch && i == 5) begin
        start    = 1'b1;
        dividend = 16'h0999;
        divisor  = 16'h0003;
      end
      tick();
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
        q_at    = quotient;
        r_at    = remainder;
      end
    end
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done_edge"}, 32'(done_at), 32'(W + 1));
    check({tag, " quotient"}, 32'(q_at), 32'(exp_q));
    check({tag, " remainder"}, 32'(r_at), 32'(exp_r));
    check({tag, " q_hold"}, 32'(quotient), 32'(exp_q));
  endtask

  initial begin
    int dc;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    tick();
    tick();
    check("rst quotient", 32'(quotient), 32'd0);
    check("rst remainder", 32'(remainder), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    tick();

    run_op("u100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0);

    // divide by zero completes on the accepting edge
    dividend = 16'h1234;
    divisor  = 16'h0000;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("dz done", 32'(done), 32'd1);
    check("dz quotient", 32'(quotient), 32'hFFFF);
    check("dz remainder", 32'(remainder), 32'h1234);
    check("dz flag", 32'(div_by_zero), 32'd1);
    check("dz busy0", 32'(busy), 32'd0);
    tick();
    check("dz done_drop", 32'(done), 32'd0);
    check("dz busy1", 32'(busy), 32'd0);
    check("dz flag_hold", 32'(div_by_zero), 32'd1);

    run_op("after_dz", 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0);

`ifdef DIV_SIGNED_EN
    run_op("s_m100_7", 16'hFF9C, 16'd7, 16'hFFF2, 16'hFFFE, 1'b0);
    run_op("s_100_m7", 16'd100, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0);
    run_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0);
`else
    run_op("u_ffff_2", 16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 1'b0);
    run_op("u_big_div", 16'h1234, 16'hF000, 16'h0000, 16'h1234, 1'b0);
`endif

    run_op("glitch", 16'd100, 16'd7, 16'd14, 16'd2, 1'b1);

    // start held high through done: second op accepted when done=1
    dividend = 16'd100;
    divisor  = 16'd7;
    start    = 1'b1;
    tick();
    for (int i = 1; i <= W + 1; i++) tick();
    check("b2b done1", 32'(done), 32'd1);
    check("b2b q1", 32'(quotient), 32'd14);
    check("b2b r1", 32'(remainder), 32'd2);
    dividend = 16'd50;
    divisor  = 16'd5;
    tick();
    start = 1'b0;
    check("b2b busy2", 32'(busy), 32'd1);
    check("b2b done_low", 32'(done), 32'd0);
    for (int i = 1; i <= W; i++) tick();
    check("b2b not_yet", 32'(done), 32'd0);
    tick();
    check("b2b done2", 32'(done), 32'd1);
    check("b2b q2", 32'(quotient), 32'd10);
    check("b2b r2", 32'(remainder), 32'd0);
    tick();
    tick();

    // reset at cycle 8 of an operation aborts it
    dividend = 16'h1234;
    divisor  = 16'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    reset = 1'b1;
    tick();
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    dc = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done || busy) dc++;
    end
    check("abort quiet", 32'(dc), 32'd0);

    run_op("u50_5", 16'd50, 16'd5, 16'd10, 16'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
